// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS-style datapath; JAL_EN adds the jal state (opcode 000011).
// FETCH-to-FETCH 3-5 cycles; FETCH/MEMRD/MEMWR stall on MemReady=0 with outputs held and no writes.
module multicycle_controller (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        ALUSrcA,
    output logic        Jal,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [4:0]  ALUControl,
    output logic        Illegal,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00001, ALU_SUB = 5'b00010, ALU_MULT = 5'b00011,
                           ALU_SLL = 5'b00100, ALU_SRL = 5'b00101, ALU_AND  = 5'b00110,
                           ALU_OR  = 5'b00111, ALU_XOR = 5'b01000, ALU_NOR  = 5'b01101,
                           ALU_SLT = 5'b01110;

    state_t      state_q, state_d;
    logic [5:0]  opcode, funct;
    logic [4:0]  rtype_alu, itype_alu;
    logic        rtype_ok;
    logic        unused_instr;

    assign opcode       = Instruction[31:26];
    assign funct        = Instruction[5:0];
    assign unused_instr = ^Instruction[25:6];

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        rtype_alu = ALU_ADD;
        rtype_ok  = 1'b1;
        case (funct)
            6'b100000: rtype_alu = ALU_ADD;
            6'b100010: rtype_alu = ALU_SUB;
            6'b011000: rtype_alu = ALU_MULT;
            6'b000000: rtype_alu = ALU_SLL;
            6'b000010: rtype_alu = ALU_SRL;
            6'b100100: rtype_alu = ALU_AND;
            6'b100101: rtype_alu = ALU_OR;
            6'b100110: rtype_alu = ALU_XOR;
            6'b100111: rtype_alu = ALU_NOR;
            6'b101010: rtype_alu = ALU_SLT;
            default:   rtype_ok  = 1'b0;
        endcase
    end

    always_comb begin
        itype_alu = ALU_ADD;
        case (opcode)
            6'b001100: itype_alu = ALU_AND;
            6'b001101: itype_alu = ALU_OR;
            6'b001110: itype_alu = ALU_XOR;
            6'b001010: itype_alu = ALU_SLT;
            default:   itype_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        ALUSrcA    = 1'b0;
        Jal        = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUControl = 5'b00000;
        Illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (opcode)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000: begin
                        // Bad funct is caught here so no R-type write cycle ever starts.
                        if (rtype_ok) state_d = S_EXEC;
                        else begin
                            Illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    6'b001000, 6'b001100, 6'b001101,
                    6'b001110, 6'b001010: state_d = S_IEXEC;
                    6'b000100, 6'b000101: state_d = S_BRANCH;
                    6'b000010:            state_d = S_JUMP;
`ifdef JAL_EN
                    6'b000011:            state_d = S_JAL;
`endif
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = rtype_alu;
                state_d    = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = itype_alu;
                state_d    = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = 2'b01;
                PCWrite    = ((opcode == 6'b000100) & Zero) | ((opcode == 6'b000101) & ~Zero);
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef JAL_EN
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                Jal      = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        // Reset squashes every strobe in the same cycle, even mid-wait.
        if (Reset) begin
            PCWrite    = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            RegDst     = 1'b0;
            MemToReg   = 1'b0;
            ALUSrcA    = 1'b0;
            Jal        = 1'b0;
            ALUSrcB    = 2'b00;
            PCSource   = 2'b00;
            ALUControl = 5'b00000;
            Illegal    = 1'b0;
        end
    end

    assign State = Reset ? 4'd0 : state_q;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Instruction, input, 32 bits: datapath IR contents, valid from DECODE onward.
REQ-004 SHALL have port Zero, input, 1 bit: ALU zero flag, sampled in BRANCH.
REQ-005 SHALL have port MemReady, input, 1 bit: memory completes the current access this cycle.
REQ-006 SHALL have outputs PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA and Jal, each output, 1 bit: datapath strobes and mux selects.
REQ-007 SHALL have outputs ALUSrcB and PCSource, each output, 2 bits: mux selects.
REQ-008 SHALL have output ALUControl, output, 5 bits: ALU operation (add 00001, sub 00010, mult 00011, sll 00100, srl 00101, and 00110, or 00111, xor 01000, nor 01101, slt 01110).
REQ-009 SHALL have output Illegal, output, 1 bit: one-cycle pulse for an unsupported instruction.
REQ-010 SHALL have output State, output, 4 bits: current state encoding.

Function
REQ-011 SHALL be a Moore FSM; outputs SHALL decode only from State, plus Instruction/Zero/MemReady where stated.
REQ-012 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JAL=12; codes 13-15 SHALL go to FETCH with all outputs 0.
REQ-013 SHALL drive every output not listed for a state to 0.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSource=00; IRWrite=PCWrite=MemReady; -> DECODE when MemReady=1, else hold.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, add; next state by opcode.
REQ-016 DECODE opcode map: 100011 (lw) and 101011 (sw) -> MEMADR; 000000 -> EXEC; 001000, 001100, 001101, 001110, 001010 -> IEXEC; 000100 and 000101 -> BRANCH; 000010 -> JUMP.
REQ-017 Any other opcode in DECODE, or an R-type funct outside REQ-020, SHALL pulse Illegal=1 and return to FETCH with no writes.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, add; -> MEMRD for lw, MEMWR for sw. MEMRD: MemRead=1, IorD=1; -> MEMWB on MemReady, else hold. MEMWR: MemWrite=1, IorD=1; -> FETCH on MemReady, else hold.
REQ-019 MEMWB: RegWrite=1, RegDst=0, MemToReg=0; -> FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00; funct 100000/100010/011000/000000/000010/100100/100101/100110/100111/101010 SHALL map to add/sub/mult/sll/srl/and/or/xor/nor/slt; -> RWB. RWB: RegWrite=1, RegDst=1, MemToReg=1; -> FETCH.
REQ-021 IEXEC: ALUSrcA=1, ALUSrcB=10; addi->add, andi->and, ori->or, xori->xor, slti->slt; -> IWB. IWB: RegWrite=1, RegDst=0, MemToReg=1; -> FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01; PCWrite=(beq&Zero)|(bne&~Zero); -> FETCH.
REQ-023 JUMP: PCSource=10, PCWrite=1; -> FETCH.
REQ-024 With MemReady held at 1, latencies SHALL be FETCH-to-FETCH: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3 cycles.
REQ-025 MemReady SHALL be ignored outside FETCH, MEMRD and MEMWR; while waiting, all outputs SHALL stay stable and no write strobe SHALL fire.

Reset
REQ-026 Reset=1 at a clock edge SHALL set State to FETCH, including mid-instruction and mid-wait.
REQ-027 While Reset=1, all outputs SHALL be forced to 0 and ALUControl to 00000.

Configuration
REQ-028 With JAL_EN defined, opcode 000011 SHALL go DECODE->JAL; JAL SHALL drive PCSource=10, PCWrite=1, RegWrite=1 and Jal=1, then go to FETCH.
REQ-029 Without JAL_EN, opcode 000011 SHALL be illegal (REQ-017), and Jal SHALL be constant 0.

Verification
REQ-030 add $3,$1,$2 (0x00221820), MemReady=1 -> State 0,1,6,7,0; ALUControl=00001 in EXEC; RegWrite=1, RegDst=1 in RWB.
REQ-031 lw (0x8C220004), MemReady low 2 cycles in MEMRD -> MEMRD held 3 cycles, MemRead=1, IorD=1, no RegWrite until MEMWB.
REQ-032 beq (0x10220003), once with Zero=1 and once with Zero=0 -> PCWrite=1 / 0 in BRANCH; PCSource=01; back to FETCH after 3 cycles.
REQ-033 opcode 111111 -> Illegal=1 for one cycle in DECODE; next State=0; no RegWrite or MemWrite.
REQ-034 Reset asserted in MEMWR with MemReady=0 -> all outputs 0 that cycle; next State=FETCH; MemWrite never 1 after the edge.
REQ-035 jal (0x0C000010), built with and without JAL_EN -> JAL state with Jal=1, RegWrite=1 when defined; Illegal pulse when not defined.
